fp_mult_stream: RTL and testbench



---
 rtl/fp_mult_stream.sv | 204 ++++++++++++++++++++
 tb/tb_fp_mult_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_stream.sv
// rtl/fp_mult_stream.sv - streaming wrapper with output FIFO around a combinational binary32 multiplier

// fp_mult: combinational IEEE-754 binary32 multiplier.
// rnd: 000 nearest-even, 001 toward zero, 010 toward +inf, 011 toward -inf,
//      100 nearest ties-away, 101 away from zero (110/111 behave as nearest-even).
// status: [0] invalid [1] overflow [2] underflow [3] inexact
//         [4] zero    [5] infinity [6] nan       [7] denormal result
// NaN results are the canonical quiet NaN 0x7FC00000.
module fp_mult (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  rnd,
   output logic [31:0] z,
   output logic [7:0]  status
);
   localparam logic [2:0] RND_NEAR = 3'b000;
   localparam logic [2:0] RND_ZERO = 3'b001;
   localparam logic [2:0] RND_POS  = 3'b010;
   localparam logic [2:0] RND_NEG  = 3'b011;
   localparam logic [2:0] RND_NMM  = 3'b100;
   localparam logic [2:0] RND_AWAY = 3'b101;

   logic               sign;
   logic [7:0]         ea, eb, ea_eff, eb_eff, exp_m1;
   logic [22:0]        fa, fb;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic [47:0]        prod, norm, sig, lost_mask;
   logic [5:0]         lz;
   logic signed [10:0] be;
   logic [7:0]         sh;
   logic               tiny, guard, sticky, inc, ovf_inf, inexact;
   logic [31:0]        rounded;

   // Unpack, multiply significands, normalise, round and classify the result
   always_comb begin
      sign   = a[31] ^ b[31];
      ea     = a[30:23];
      eb     = b[30:23];
      fa     = a[22:0];
      fb     = b[22:0];
      a_zero = (ea == 8'd0) && (fa == 23'd0);
      b_zero = (eb == 8'd0) && (fb == 23'd0);
      a_inf  = (ea == 8'hFF) && (fa == 23'd0);
      b_inf  = (eb == 8'hFF) && (fb == 23'd0);
      a_nan  = (ea == 8'hFF) && (fa != 23'd0);
      b_nan  = (eb == 8'hFF) && (fb != 23'd0);
      a_snan = a_nan && !fa[22];
      b_snan = b_nan && !fb[22];
      ea_eff = (ea == 8'd0) ? 8'd1 : ea;
      eb_eff = (eb == 8'd0) ? 8'd1 : eb;

      prod = {24'd0, (ea != 8'd0), fa} * {24'd0, (eb != 8'd0), fb};
      lz = 6'd0;
      for (int i = 0; i < 48; i++) begin
         if (prod[i]) lz = 6'(47 - i);
      end
      norm = prod << lz;

      // Biased exponent of the value 1.xxx * 2^E held in norm with its leading one at bit 47
      be   = 11'(ea_eff) + 11'(eb_eff) - 11'sd126 - 11'(lz);
      tiny = (be < 11'sd1);
      sh   = tiny ? 8'(11'sd1 - be) : 8'd0;

      // Tiny results are denormalised by shifting right; everything shifted out feeds sticky
      lost_mask = (48'd1 << sh) - 48'd1;
      sig       = norm >> sh;
      guard     = sig[23];
      sticky    = (|sig[22:0]) | (|(norm & lost_mask));
      inexact   = guard | sticky;

      case (rnd)
         RND_ZERO: inc = 1'b0;
         RND_POS:  inc = !sign && inexact;
         RND_NEG:  inc = sign && inexact;
         RND_NMM:  inc = guard;
         RND_AWAY: inc = inexact;
         default:  inc = guard && (sticky || sig[24]);
      endcase
      ovf_inf = (rnd == RND_NEAR) || (rnd == RND_NMM) || (rnd == RND_AWAY) ||
                (rnd[2:1] == 2'b11) || ((rnd == RND_POS) && !sign) ||
                ((rnd == RND_NEG) && sign);

      // The hidden bit carries into exponent-1, so a rounding carry propagates naturally
      exp_m1  = tiny ? 8'd0 : 8'(be - 11'sd1);
      rounded = {1'b0, exp_m1, 23'd0} + {8'd0, sig[47:24]} + {31'd0, inc};

      z      = {sign, rounded[30:0]};
      status = 8'd0;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         z         = 32'h7FC0_0000;
         status[0] = a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf);
         status[6] = 1'b1;
      end else if (a_inf || b_inf) begin
         z         = {sign, 8'hFF, 23'd0};
         status[5] = 1'b1;
      end else if (a_zero || b_zero) begin
         z         = {sign, 31'd0};
         status[4] = 1'b1;
      end else if ((be >= 11'sd255) || (rounded[30:23] == 8'hFF)) begin
         z         = ovf_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7F_FFFF};
         status[1] = 1'b1;
         status[3] = 1'b1;
         status[5] = ovf_inf;
      end else begin
         status[2] = tiny && inexact;
         status[3] = inexact;
         status[4] = (rounded[30:0] == 31'd0);
         status[7] = (rounded[30:23] == 8'd0) && (rounded[22:0] != 23'd0);
      end
   end
endmodule

// fp_mult_stream: S1 operand register -> fp_mult -> S2 result register -> output FIFO.
// Input credit counts FIFO entries plus both pipeline stages, so pushes never overflow.
module fp_mult_stream #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [2:0]       in_rnd,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_z,
   output logic [7:0]       out_status,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      cnt_in,
   output logic [15:0]      cnt_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 32 + 8 + TAG_W;
   localparam logic [AW+1:0] DEPTH_C = (AW + 2)'(DEPTH);

   logic [31:0]      s1_a, s1_b;
   logic [2:0]       s1_rnd;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_v;
   logic [31:0]      core_z;
   logic [7:0]       core_status;
   logic [EW-1:0]    s2_data;
   logic             s2_v;
   logic [EW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic [AW+1:0]    credit;
   logic             accept, pop;
   logic [EW-1:0]    head;

   fp_mult u_core (
      .a      (s1_a),
      .b      (s1_b),
      .rnd    (s1_rnd),
      .z      (core_z),
      .status (core_status)
   );

   assign credit    = {1'b0, count} + {{(AW + 1){1'b0}}, s1_v} + {{(AW + 1){1'b0}}, s2_v};
   assign in_ready  = !rst && (credit < DEPTH_C);
   assign accept    = in_valid && in_ready;
   assign out_valid = !rst && (count != '0);
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_ptr];
   assign out_z      = out_valid ? head[EW-1 -: 32] : 32'd0;
   assign out_status = out_valid ? head[TAG_W +: 8] : 8'd0;
   assign out_tag    = out_valid ? head[TAG_W-1:0] : '0;

   // Datapath registers: S1 operands on accept, S2 result every cycle, FIFO write on S2 valid
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a   <= in_a;
         s1_b   <= in_b;
         s1_rnd <= in_rnd;
         s1_tag <= in_tag;
      end
      s2_data <= {core_z, core_status, s1_tag};
      if (s2_v) mem[wr_ptr] <= s2_data;
   end

   // Control state: stage valids, FIFO pointers/occupancy and operation counters
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s2_v    <= 1'b0;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_in  <= 16'd0;
         cnt_out <= 16'd0;
      end else begin
         s1_v  <= accept;
         s2_v  <= s1_v;
         count <= count + {{AW{1'b0}}, s2_v} - {{AW{1'b0}}, pop};
         if (s2_v)   wr_ptr  <= wr_ptr + 1'b1;
         if (pop)    rd_ptr  <= rd_ptr + 1'b1;
         if (accept) cnt_in  <= cnt_in + 16'd1;
         if (pop)    cnt_out <= cnt_out + 16'd1;
      end
   end
endmodule

// File: tb/tb_fp_mult_stream.sv
// tb/tb_fp_mult_stream.sv - scoreboard bench for fp_mult_stream with directed vectors
module tb_fp_mult_stream;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_a = 32'd0;
   logic [31:0]      in_b = 32'd0;
   logic [2:0]       in_rnd = 3'd0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_z;
   logic [7:0]       out_status;
   logic [TAG_W-1:0] out_tag;
   logic [15:0]      cnt_in, cnt_out;

   fp_mult_stream #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_status(out_status), .out_tag(out_tag),
      .cnt_in(cnt_in), .cnt_out(cnt_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] z;
      logic [7:0]  st;
      logic [3:0]  tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;

   localparam logic [31:0] ONE = 32'h3F80_0000;
   logic [31:0] stream_b [16] = '{
      32'h4049_0FDB, 32'hC000_0000, 32'h3F00_0000, 32'h42F6_0000,
      32'h3DCC_CCCD, 32'hBF80_0000, 32'h7F7F_FFFF, 32'h0080_0000,
      32'h4B00_0000, 32'hC2C8_0000, 32'h3EAA_AAAB, 32'h447A_0000,
      32'h8080_0000, 32'h3F7F_FFFF, 32'h40A0_0000, 32'hC120_0000};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: any result handed to the consumer must match the oldest expectation
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got z=%h tag=%h, required no output", out_z, out_tag);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_z", 64'(out_z), 64'(mon_e.z));
            check("out_status", 64'(out_status), 64'(mon_e.st));
            check("out_tag", 64'(out_tag), 64'(mon_e.tag));
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r,
                       input logic [3:0] t, input logic [31:0] ez, input logic [7:0] est,
                       output int waits);
      bit done;
      done = 0;
      waits = 0;
      in_a = a; in_b = b; in_rnd = r; in_tag = t; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            exp_q.push_back(exp_t'({ez, est, t}));
            done = 1;
         end else begin
            waits++;
            if (waits > 200) begin
               n_checks++;
               n_fail++;
               $display("FAIL send_timeout: got no accept in %0d cycles, required accept", waits);
               done = 1;
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int c;
      c = 0;
      while ((exp_q.size() != 0 || out_valid !== 1'b0) && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      check("drain_done", 64'(c < 300), 64'd1);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic latency3();
      @(negedge clk); check("lat_cycle1", 64'(out_valid), 64'd0);
      @(negedge clk); check("lat_cycle2", 64'(out_valid), 64'd0);
      @(negedge clk); check("lat_cycle3", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
   endtask

   // Hand-derived results for the corner operand pairs in each rounding mode
   function automatic logic [39:0] corner_exp(input int c, input int m);
      case (c)
         0: return {32'h7FC0_0000, 8'h41};
         1: return {32'h7FC0_0000, 8'h41};
         2: return {32'h8000_0001, 8'h80};
         3: return (m == 1 || m == 3) ? {32'h0000_0001, 8'h8C} : {32'h0000_0002, 8'h8C};
         4: return (m == 1 || m == 3) ? {32'h7F7F_FFFF, 8'h0A} : {32'h7F80_0000, 8'h2A};
         default: return {32'h8000_0000, 8'h10};
      endcase
   endfunction

   logic [31:0] corner_a [6] = '{32'h7F80_0001, 32'h7F80_0000, 32'hBF80_0000,
                                 32'h3FC0_0000, 32'h7F00_0000, 32'h3F80_0000};
   logic [31:0] corner_b [6] = '{32'h3F80_0000, 32'h0000_0000, 32'h0000_0001,
                                 32'h0000_0001, 32'h4000_0000, 32'h8000_0000};

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      int          acc;
      int          idx;
      logic [39:0] ce;
      logic [31:0] bw;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_z", 64'({out_z, out_status, out_tag}), 64'd0);
      check("rst_cnt", 64'({cnt_in, cnt_out}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Basic 4.0 * 2.0 with latency
      out_ready = 1'b1;
      send(32'h4080_0000, 32'h4000_0000, 3'd0, 4'd3, 32'h4100_0000, 8'h00, w);
      latency3();
      drain();

      // Stream of 16 back-to-back ops
      pulse_reset();
      for (int i = 0; i < 16; i++) begin
         send(ONE, stream_b[i], 3'd0, 4'(i), stream_b[i], 8'h00, w);
         check("stream_in_ready", 64'(w), 64'd0);
      end
      drain();
      check("stream_cnt_in", 64'(cnt_in), 64'd16);
      check("stream_cnt_out", 64'(cnt_out), 64'd16);

      // Backpressure: consumer stalled, producer always valid
      pulse_reset();
      out_ready = 1'b0;
      acc = 0;
      in_a = ONE; in_b = stream_b[0]; in_rnd = 3'd0; in_tag = 4'd0; in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            exp_q.push_back(exp_t'({stream_b[acc], 8'h00, 4'(acc)}));
            acc++;
         end
         @(posedge clk); #1;
         in_b = stream_b[acc]; in_tag = 4'(acc);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_accepts", 64'(acc), 64'd4);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_head_z", 64'(out_z), 64'(stream_b[0]));
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_head_hold", 64'({out_z, out_tag}), 64'({stream_b[0], 4'd0}));
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 4; i < 8; i++) send(ONE, stream_b[i], 3'd0, 4'(i), stream_b[i], 8'h00, w);
      drain();
      check("bp_cnt_in", 64'(cnt_in), 64'd8);
      check("bp_cnt_out", 64'(cnt_out), 64'd8);

      // Corner operands in all six rounding modes
      for (int m = 0; m < 6; m++) begin
         for (int c = 0; c < 6; c++) begin
            ce = corner_exp(c, m);
            send(corner_a[c], corner_b[c], 3'(m), 4'(c), ce[39:8], ce[7:0], w);
         end
      end
      drain();

      // Reset mid-flight
      pulse_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(ONE, stream_b[i], 3'd0, 4'(i), stream_b[i], 8'h00, w);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("after_rst_in_ready", 64'(in_ready), 64'd1);
      check("after_rst_out_valid", 64'(out_valid), 64'd0);
      check("after_rst_cnt", 64'({cnt_in, cnt_out}), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      send(32'h4080_0000, 32'h4000_0000, 3'd0, 4'd9, 32'h4100_0000, 8'h00, w);
      latency3();
      drain();

      // Counter and pointer wrap
      pulse_reset();
      idx = 0;
      for (int i = 0; i < 65538; i++) begin
         bw = {1'b0, 8'd127, 23'(i)};
         send(ONE, bw, 3'(i % 6), 4'(i), bw, 8'h00, w);
      end
      drain();
      check("wrap_cnt_in", 64'(cnt_in), 64'd2);
      check("wrap_cnt_out", 64'(cnt_out), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
